// File: rtl/spu_result_pipe.sv
// spu_result_pipe: multi-lane MEM-to-WB result delay pipeline for the dual-issue SPU.
// Carries result, load data and destination register per lane for DEPTH stages,
// selects writeback data at the last stage and answers NQ forwarding queries.
// Optional build macro: SPU_RESULT_PIPE_WB_FWD_EN
//   defined   -> the forwarding search also covers stage DEPTH (lowest priority)
//   undefined -> stage DEPTH is left to the register file's write-before-read
// Stage s (1..DEPTH) is stored at array index s-1.
module spu_result_pipe #(
    parameter int LANES       = 2,
    parameter int DEPTH       = 6,
    parameter int LOAD_STAGE  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int NQ          = 3,
    parameter int DATA_W      = 128,
    parameter int RT_W        = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0]        in_reg_we,
    input  logic [LANES-1:0]        in_mem_to_reg,
    input  logic [LANES*RT_W-1:0]   in_rt,
    input  logic [LANES*DATA_W-1:0] in_result,
    input  logic [LANES*DATA_W-1:0] ld_data,
    output logic [LANES-1:0]        wb_we,
    output logic [LANES*RT_W-1:0]   wb_rt,
    output logic [LANES*DATA_W-1:0] wb_data,
    input  logic [NQ*RT_W-1:0]      q_addr,
    output logic [NQ-1:0]           q_hit,
    output logic [NQ-1:0]           q_ready,
    output logic [NQ*DATA_W-1:0]    q_data
);

`ifdef SPU_RESULT_PIPE_WB_FWD_EN
    localparam int FWD_STAGES = DEPTH;
`else
    localparam int FWD_STAGES = DEPTH - 1;
`endif

    logic              stgValid_r  [DEPTH][LANES];
    logic              stgWe_r     [DEPTH][LANES];
    logic              stgM2r_r    [DEPTH][LANES];
    logic [RT_W-1:0]   stgRt_r     [DEPTH][LANES];
    logic [DATA_W-1:0] stgResult_r [DEPTH][LANES];
    logic [DATA_W-1:0] stgMdata_r  [DEPTH][LANES];

    // Stage registers: clear on reset, advance or hold, then kill the young stages on flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    stgValid_r[s][l]  <= 1'b0;
                    stgWe_r[s][l]     <= 1'b0;
                    stgM2r_r[s][l]    <= 1'b0;
                    stgRt_r[s][l]     <= '0;
                    stgResult_r[s][l] <= '0;
                    stgMdata_r[s][l]  <= '0;
                end
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (!stall) begin
                    // Entry point: a lane without in_valid becomes a bubble.
                    stgValid_r[0][l]  <= in_valid[l];
                    stgWe_r[0][l]     <= in_reg_we[l];
                    stgM2r_r[0][l]    <= in_mem_to_reg[l];
                    stgRt_r[0][l]     <= in_rt[l*RT_W +: RT_W];
                    stgResult_r[0][l] <= in_result[l*DATA_W +: DATA_W];
                    stgMdata_r[0][l]  <= '0;
                    for (int s = 1; s < DEPTH; s++) begin
                        stgValid_r[s][l]  <= stgValid_r[s-1][l];
                        stgWe_r[s][l]     <= stgWe_r[s-1][l];
                        stgM2r_r[s][l]    <= stgM2r_r[s-1][l];
                        stgRt_r[s][l]     <= stgRt_r[s-1][l];
                        stgResult_r[s][l] <= stgResult_r[s-1][l];
                        // Load data is captured as the entry leaves LOAD_STAGE.
                        if (s == LOAD_STAGE) begin
                            stgMdata_r[s][l] <= ld_data[l*DATA_W +: DATA_W];
                        end else begin
                            stgMdata_r[s][l] <= stgMdata_r[s-1][l];
                        end
                    end
                end
                // Flush overrides both the hold and the newly captured input.
                for (int s = 0; s < DEPTH; s++) begin
                    if (flush && (s < FLUSH_DEPTH)) begin
                        stgValid_r[s][l] <= 1'b0;
                    end
                end
            end
        end
    end

    // Writeback from the last stage; a stalled cycle suppresses the write so it happens once.
    always_comb begin
        wb_we   = '0;
        wb_rt   = '0;
        wb_data = '0;
        for (int l = 0; l < LANES; l++) begin
            wb_we[l]                   = stgValid_r[DEPTH-1][l] & stgWe_r[DEPTH-1][l] & ~stall;
            wb_rt[l*RT_W +: RT_W]      = stgRt_r[DEPTH-1][l];
            if (stgM2r_r[DEPTH-1][l]) begin
                wb_data[l*DATA_W +: DATA_W] = stgMdata_r[DEPTH-1][l];
            end else begin
                wb_data[l*DATA_W +: DATA_W] = stgResult_r[DEPTH-1][l];
            end
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest candidate is the last to win,
    // including a not-ready younger load masking an older ready match.
    always_comb begin
        q_hit   = '0;
        q_ready = '0;
        q_data  = '0;
        for (int q = 0; q < NQ; q++) begin
            for (int s = FWD_STAGES - 1; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (stgValid_r[s][l] && stgWe_r[s][l] &&
                        (stgRt_r[s][l] == q_addr[q*RT_W +: RT_W])) begin
                        q_hit[q] = 1'b1;
                        if (!stgM2r_r[s][l]) begin
                            q_ready[q]                 = 1'b1;
                            q_data[q*DATA_W +: DATA_W] = stgResult_r[s][l];
                        end else if (s >= LOAD_STAGE) begin
                            q_ready[q]                 = 1'b1;
                            q_data[q*DATA_W +: DATA_W] = stgMdata_r[s][l];
                        end else begin
                            q_ready[q]                 = 1'b0;
                            q_data[q*DATA_W +: DATA_W] = '0;
                        end
                    end else begin
                        q_hit[q] = q_hit[q];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spu_result_pipe.sv
// Self-checking bench for spu_result_pipe: directed scenarios plus randomized traffic
// compared against a queue-of-instructions reference model.
`timescale 1ns/1ps
module tb_spu_result_pipe;
    localparam int LANES = 2, DEPTH = 6, LOAD_STAGE = 1, FLUSH_DEPTH = 2, NQ = 3, DW = 128, RW = 7;
`ifdef SPU_RESULT_PIPE_WB_FWD_EN
    localparam int FWD_MAX = DEPTH;
`else
    localparam int FWD_MAX = DEPTH - 1;
`endif

    logic clk = 1'b0;
    logic reset, stall, flush;
    logic [LANES-1:0]    in_valid, in_reg_we, in_mem_to_reg, wb_we;
    logic [LANES*RW-1:0] in_rt, wb_rt;
    logic [LANES*DW-1:0] in_result, ld_data, wb_data;
    logic [NQ*RW-1:0]    q_addr;
    logic [NQ-1:0]       q_hit, q_ready;
    logic [NQ*DW-1:0]    q_data;

    int errors = 0;
    int checks = 0;

    spu_result_pipe #(.LANES(LANES), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FLUSH_DEPTH(FLUSH_DEPTH),
                      .NQ(NQ), .DATA_W(DW), .RT_W(RW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_we(in_reg_we), .in_mem_to_reg(in_mem_to_reg),
        .in_rt(in_rt), .in_result(in_result), .ld_data(ld_data),
        .wb_we(wb_we), .wb_rt(wb_rt), .wb_data(wb_data),
        .q_addr(q_addr), .q_hit(q_hit), .q_ready(q_ready), .q_data(q_data));

    always #5 clk = ~clk;

    // Reference model: one record per accepted instruction; adv = stage it occupies.
    typedef struct {
        int            lane;
        bit            we;
        bit            m2r;
        logic [RW-1:0] rt;
        logic [DW-1:0] result;
        logic [DW-1:0] mdata;
        int            adv;
    } rec_t;
    rec_t pipe_q[$];

    logic [LANES-1:0]    e_wb_we, e_wb_has;
    logic [LANES*RW-1:0] e_wb_rt;
    logic [LANES*DW-1:0] e_wb_data;
    logic [NQ-1:0]       e_hit, e_ready;
    logic [NQ*DW-1:0]    e_qdata;

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_update();
        rec_t nq[$];
        rec_t r;
        if (reset === 1'b0) begin
            pipe_q.delete();
        end else begin
            foreach (pipe_q[i]) begin
                r = pipe_q[i];
                if (!stall) r.adv++;
                if (!stall && r.adv == LOAD_STAGE + 1) r.mdata = ld_data[r.lane*DW +: DW];
                if (r.adv <= DEPTH && !(flush && r.adv <= FLUSH_DEPTH)) nq.push_back(r);
            end
            if (!stall && !flush) begin
                for (int l = 0; l < LANES; l++) begin
                    if (in_valid[l]) begin
                        r.lane = l; r.we = in_reg_we[l]; r.m2r = in_mem_to_reg[l];
                        r.rt = in_rt[l*RW +: RW]; r.result = in_result[l*DW +: DW];
                        r.mdata = '0; r.adv = 1;
                        nq.push_back(r);
                    end
                end
            end
            pipe_q = nq;
        end
    endtask

    task automatic model_outputs();
        int best;
        e_wb_we = '0; e_wb_has = '0; e_wb_rt = '0; e_wb_data = '0;
        e_hit = '0; e_ready = '0; e_qdata = '0;
        foreach (pipe_q[i]) begin
            if (pipe_q[i].adv == DEPTH) begin
                e_wb_has[pipe_q[i].lane] = 1'b1;
                e_wb_we[pipe_q[i].lane]  = pipe_q[i].we && !stall;
                e_wb_rt[pipe_q[i].lane*RW +: RW] = pipe_q[i].rt;
                e_wb_data[pipe_q[i].lane*DW +: DW] = pipe_q[i].m2r ? pipe_q[i].mdata : pipe_q[i].result;
            end
        end
        for (int q = 0; q < NQ; q++) begin
            best = -1;
            foreach (pipe_q[i]) begin
                if (pipe_q[i].we && pipe_q[i].rt == q_addr[q*RW +: RW] && pipe_q[i].adv <= FWD_MAX) begin
                    if (best < 0 || pipe_q[i].adv < pipe_q[best].adv ||
                        (pipe_q[i].adv == pipe_q[best].adv && pipe_q[i].lane > pipe_q[best].lane))
                        best = i;
                end
            end
            if (best >= 0) begin
                e_hit[q] = 1'b1;
                if (!pipe_q[best].m2r || pipe_q[best].adv > LOAD_STAGE) begin
                    e_ready[q] = 1'b1;
                    e_qdata[q*DW +: DW] = pipe_q[best].m2r ? pipe_q[best].mdata : pipe_q[best].result;
                end
            end
        end
    endtask

    task automatic idle();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = '0; in_reg_we = '0; in_mem_to_reg = '0; in_rt = '0; in_result = '0;
        ld_data = '0; q_addr = '0;
    endtask

    task automatic issue(input int lane, input bit we, input bit m2r, input logic [RW-1:0] rt,
                         input logic [DW-1:0] res);
        in_valid[lane] = 1'b1; in_reg_we[lane] = we; in_mem_to_reg[lane] = m2r;
        in_rt[lane*RW +: RW] = rt; in_result[lane*DW +: DW] = res;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        idle(); reset = 1'b0; in_valid = '1; in_reg_we = '1;
        in_rt = {7'd3, 7'd3}; in_result = {rnd128(), rnd128()}; q_addr = {7'd3, 7'd3, 7'd3};
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (wb_we !== '0)   begin errors++; $display("FAIL reset_wb_we: got %h want 0", wb_we); end
            checks++; if (wb_rt !== '0)   begin errors++; $display("FAIL reset_wb_rt: got %h want 0", wb_rt); end
            checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
            checks++; if (q_hit !== '0)   begin errors++; $display("FAIL reset_q_hit: got %b want 0", q_hit); end
            checks++; if (q_ready !== '0) begin errors++; $display("FAIL reset_q_ready: got %b want 0", q_ready); end
            checks++; if (q_data !== '0)  begin errors++; $display("FAIL reset_q_data: got %h want 0", q_data); end
            tick();
        end
        idle();
    endtask

    task automatic test_latency();
        logic [DW-1:0] pat;
        logic [1:0] exp_we;
        pat = {16{8'hA5}};
        idle(); issue(0, 1'b1, 1'b0, 7'd5, pat); tick();
        for (int k = 1; k <= 8; k++) begin
            idle(); #1;
            exp_we = (k == 6) ? 2'b01 : 2'b00;
            checks++; if (wb_we !== exp_we) begin errors++; $display("FAIL latency_we c%0d: got %b want %b", k, wb_we, exp_we); end
            if (k == 6) begin
                checks++; if (wb_rt[RW-1:0] !== 7'd5) begin errors++; $display("FAIL latency_rt: got %0d want 5", wb_rt[RW-1:0]); end
                checks++; if (wb_data[DW-1:0] !== pat) begin errors++; $display("FAIL latency_data: got %h want %h", wb_data[DW-1:0], pat); end
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [1:0] exp_we;
        idle(); issue(1, 1'b1, 1'b1, 7'd9, rnd128()); tick();
        idle(); ld_data = {128'h1234, rnd128()}; q_addr = {7'd9, 7'd9, 7'd9}; #1;
        checks++; if (q_hit !== 3'b111)   begin errors++; $display("FAIL load_s1_hit: got %b want 111", q_hit); end
        checks++; if (q_ready !== 3'b000) begin errors++; $display("FAIL load_s1_ready: got %b want 000", q_ready); end
        checks++; if (q_data !== '0)      begin errors++; $display("FAIL load_s1_data: got %h want 0", q_data[DW-1:0]); end
        tick();
        idle(); ld_data = {rnd128(), rnd128()}; q_addr = {7'd9, 7'd9, 7'd9}; #1;
        checks++; if (q_hit !== 3'b111)   begin errors++; $display("FAIL load_s2_hit: got %b want 111", q_hit); end
        checks++; if (q_ready !== 3'b111) begin errors++; $display("FAIL load_s2_ready: got %b want 111", q_ready); end
        checks++; if (q_data[DW-1:0] !== 128'h1234) begin errors++; $display("FAIL load_s2_data: got %h want 1234", q_data[DW-1:0]); end
        tick();
        for (int k = 3; k <= 7; k++) begin
            idle(); ld_data = {rnd128(), rnd128()}; #1;
            exp_we = (k == 6) ? 2'b10 : 2'b00;
            checks++; if (wb_we !== exp_we) begin errors++; $display("FAIL load_wb_we c%0d: got %b want %b", k, wb_we, exp_we); end
            if (k == 6) begin
                checks++; if (wb_data[DW +: DW] !== 128'h1234) begin errors++; $display("FAIL load_wb_data: got %h want 1234", wb_data[DW +: DW]); end
            end
            tick();
        end
    endtask

    task automatic test_priority();
        idle(); issue(0, 1'b1, 1'b0, 7'd4, 128'h11); tick();
        idle(); issue(0, 1'b1, 1'b0, 7'd4, 128'h22); issue(1, 1'b1, 1'b0, 7'd4, 128'h33); tick();
        for (int k = 0; k < 2; k++) begin
            idle(); q_addr = {7'd77, 7'd4, 7'd4}; #1;
            checks++; if (q_hit !== 3'b011) begin errors++; $display("FAIL prio_hit k%0d: got %b want 011", k, q_hit); end
            checks++; if (q_ready[1:0] !== 2'b11) begin errors++; $display("FAIL prio_ready k%0d: got %b want 11", k, q_ready[1:0]); end
            checks++; if (q_data[DW-1:0] !== 128'h33) begin errors++; $display("FAIL prio_data k%0d: got %h want 33", k, q_data[DW-1:0]); end
            tick();
        end
        drain();
        idle(); issue(0, 1'b1, 1'b0, 7'd4, 128'h11); tick();
        idle(); issue(0, 1'b1, 1'b0, 7'd4, 128'h22); issue(1, 1'b1, 1'b1, 7'd4, 128'h33); tick();
        idle(); q_addr = {7'd77, 7'd77, 7'd4}; ld_data = {128'h44, 128'h0}; #1;
        checks++; if (q_hit[0] !== 1'b1)   begin errors++; $display("FAIL prio_ld_hit: got %b want 1", q_hit[0]); end
        checks++; if (q_ready[0] !== 1'b0) begin errors++; $display("FAIL prio_ld_ready: got %b want 0", q_ready[0]); end
        checks++; if (q_data[DW-1:0] !== '0) begin errors++; $display("FAIL prio_ld_data: got %h want 0", q_data[DW-1:0]); end
        tick();
        idle(); q_addr = {7'd77, 7'd77, 7'd4}; #1;
        checks++; if (q_ready[0] !== 1'b1 || q_data[DW-1:0] !== 128'h44) begin
            errors++; $display("FAIL prio_ld_later: got ready=%b data=%h want 1/44", q_ready[0], q_data[DW-1:0]); end
        tick();
        drain();
    endtask

    task automatic test_stall();
        logic [1:0] exp_we;
        idle(); issue(0, 1'b1, 1'b0, 7'd12, 128'hBEEF); tick();
        for (int k = 1; k <= 11; k++) begin
            idle();
            stall = (k >= 4 && k <= 6);
            if (stall) begin
                issue(0, 1'b1, 1'b0, 7'd13, 128'h1); issue(1, 1'b1, 1'b0, 7'd13, 128'h2);
            end
            q_addr = {7'd13, 7'd13, 7'd13}; #1;
            exp_we = (k == 9) ? 2'b01 : 2'b00;
            checks++; if (wb_we !== exp_we) begin errors++; $display("FAIL stall_we c%0d: got %b want %b", k, wb_we, exp_we); end
            checks++; if (q_hit !== 3'b000) begin errors++; $display("FAIL stall_capture c%0d: got %b want 000", k, q_hit); end
            if (k == 9) begin
                checks++; if (wb_data[DW-1:0] !== 128'hBEEF) begin errors++; $display("FAIL stall_data: got %h want beef", wb_data[DW-1:0]); end
            end
            tick();
        end
    endtask

    task automatic test_flush(input bit with_stall);
        int fk, wbk;
        logic [1:0] exp_we;
        logic [2:0] exp_hit;
        fk  = with_stall ? 3 : 2;
        wbk = with_stall ? 7 : 6;
        for (int k = 0; k <= 10; k++) begin
            idle();
            if (k <= 2) issue(0, 1'b1, 1'b0, RW'(21 + k), DW'(256 + k));
            stall = with_stall && (k == 3);
            flush = (k == fk);
            q_addr = {7'd23, 7'd22, 7'd21}; #1;
            exp_we = (k == wbk) ? 2'b01 : 2'b00;
            checks++; if (wb_we !== exp_we) begin errors++; $display("FAIL flush%0d_we c%0d: got %b want %b", with_stall, k, wb_we, exp_we); end
            if (k == fk || k == fk + 1) begin
                exp_hit = (k == fk + 1) ? 3'b001 : (with_stall ? 3'b111 : 3'b011);
                checks++; if (q_hit !== exp_hit) begin errors++; $display("FAIL flush%0d_hit c%0d: got %b want %b", with_stall, k, q_hit, exp_hit); end
            end
            if (k == wbk) begin
                checks++; if (wb_data[DW-1:0] !== 128'h100) begin errors++; $display("FAIL flush%0d_data: got %h want 100", with_stall, wb_data[DW-1:0]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k <= 12; k++) begin
            idle();
            if (k <= 2) begin
                issue(0, 1'b1, 1'b0, RW'(30 + 2*k), rnd128()); issue(1, 1'b1, 1'b0, RW'(31 + 2*k), rnd128());
            end
            reset = (k == 3) ? 1'b0 : 1'b1;
            q_addr = {7'd35, 7'd32, 7'd30}; #1;
            checks++; if (wb_we !== 2'b00) begin errors++; $display("FAIL rstmid_we c%0d: got %b want 00", k, wb_we); end
            if (k == 3) begin
                checks++; if (q_hit !== 3'b111) begin errors++; $display("FAIL rstmid_prehit: got %b want 111", q_hit); end
            end
            if (k >= 4) begin
                checks++; if (q_hit !== 3'b000) begin errors++; $display("FAIL rstmid_hit c%0d: got %b want 000", k, q_hit); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            idle();
            reset = ($urandom_range(0, 59) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 11) == 0);
            for (int l = 0; l < LANES; l++) begin
                in_valid[l] = 1'($urandom_range(0, 1)); in_reg_we[l] = 1'($urandom_range(0, 3) != 0);
                in_mem_to_reg[l] = 1'($urandom_range(0, 1));
                in_rt[l*RW +: RW] = RW'($urandom_range(0, 7));
                in_result[l*DW +: DW] = rnd128(); ld_data[l*DW +: DW] = rnd128();
            end
            for (int q = 0; q < NQ; q++) q_addr[q*RW +: RW] = RW'($urandom_range(0, 7));
            #1;
            model_outputs();
            for (int l = 0; l < LANES; l++) begin
                checks++; if (wb_we[l] !== e_wb_we[l]) begin errors++; $display("FAIL rnd_wb_we n%0d l%0d: got %b want %b", n, l, wb_we[l], e_wb_we[l]); end
                if (e_wb_has[l]) begin
                    checks++; if (wb_rt[l*RW +: RW] !== e_wb_rt[l*RW +: RW]) begin errors++; $display("FAIL rnd_wb_rt n%0d l%0d: got %0d want %0d", n, l, wb_rt[l*RW +: RW], e_wb_rt[l*RW +: RW]); end
                    checks++; if (wb_data[l*DW +: DW] !== e_wb_data[l*DW +: DW]) begin errors++; $display("FAIL rnd_wb_data n%0d l%0d: got %h want %h", n, l, wb_data[l*DW +: DW], e_wb_data[l*DW +: DW]); end
                end
            end
            for (int q = 0; q < NQ; q++) begin
                checks++; if (q_hit[q] !== e_hit[q]) begin errors++; $display("FAIL rnd_q_hit n%0d q%0d: got %b want %b", n, q, q_hit[q], e_hit[q]); end
                checks++; if (q_ready[q] !== e_ready[q]) begin errors++; $display("FAIL rnd_q_ready n%0d q%0d: got %b want %b", n, q, q_ready[q], e_ready[q]); end
                checks++; if (q_data[q*DW +: DW] !== e_qdata[q*DW +: DW]) begin errors++; $display("FAIL rnd_q_data n%0d q%0d: got %h want %h", n, q, q_data[q*DW +: DW], e_qdata[q*DW +: DW]); end
            end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_latency();
        test_load();
        test_priority();
        test_stall();
        test_flush(1'b0);
        test_flush(1'b1);
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spu_result_pipe.md
Name: spu_result_pipe

Overview:
- Parametrised, multi-lane result delay pipeline running from the MEM stage to writeback in the dual-issue SPU core.
- Replaces the fixed chain of six two-lane per-stage delay registers and the separate writeback data mux.
- Carries each lane's result, load data and destination register for DEPTH stages, then selects the writeback data.
- Adds stall, flush and a multi-port forwarding lookup with load-readiness reporting.

Parameters:
- LANES, 2, issue lanes; lane index order equals program order, so a higher lane is younger.
- DEPTH, 6, number of stages from MEM to WB; legal range 2..16.
- LOAD_STAGE, 1, stage at which load data is captured; must be less than DEPTH.
- FLUSH_DEPTH, 2, number of youngest stages (1..FLUSH_DEPTH) killed by flush.
- NQ, 3, forwarding query ports.
- DATA_W, 128, result width.
- RT_W, 7, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  freeze all stages.
- flush  in  1  kill young stages.
- in_valid  in  LANES  lane issue valid.
- in_reg_we  in  LANES  regWriteEnable per lane.
- in_mem_to_reg  in  LANES  result comes from memory.
- in_rt  in  LANES*RT_W  destination register.
- in_result  in  LANES*DATA_W  EX result.
- ld_data  in  LANES*DATA_W  memory read data for the entry currently in stage LOAD_STAGE.
- wb_we  out  LANES  register file write enable.
- wb_rt  out  LANES*RT_W  write address.
- wb_data  out  LANES*DATA_W  write data.
- q_addr  in  NQ*RT_W  forwarding query address.
- q_hit  out  NQ  a matching in-flight write exists.
- q_ready  out  NQ  data for the youngest match is available.
- q_data  out  NQ*DATA_W  forwarded data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on port reset. While reset is 0 at a rising clk edge:
  - all stage valid bits clear;
  - all stored fields clear to 0;
  - wb_we=0, wb_rt=0, wb_data=0;
  - q_hit=0, q_ready=0, q_data=0.
- Reset mid-operation discards every in-flight entry; nothing is written back.
- Entry contents, per stage s (1..DEPTH) and lane: valid, we, m2r, rt, result, mdata.
- Advance (stall=0): stage 1 is loaded from the in_* inputs. Stage s+1 is loaded from stage s. Entries with in_valid=0 become bubbles (valid=0).
- Load capture: when an entry advances out of LOAD_STAGE, its mdata is loaded from that lane's ld_data. ld_data is ignored otherwise.
- Stall (stall=1): every stage holds its contents and in_* is ignored. The source must re-present the instruction.
- Flush (flush=1): after the advance/hold update, valid clears in stages 1..FLUSH_DEPTH.
  - With stall=1 and flush=1, the hold applies and those stages are then cleared.
  - Flush has priority over capture of new input.
- Latency: an instruction accepted at cycle t with no stalls drives the wb outputs during cycle t+DEPTH. Each stall cycle adds one cycle.
- Writeback, per lane, from stage DEPTH:
  - wb_we = valid & we & ~stall (one write per entry even across stalls);
  - wb_rt = rt;
  - wb_data = m2r ? mdata : result.
- If two lanes in stage DEPTH write the same rt, both wb_we assert. The register file gives the higher lane priority.
- Forwarding (combinational), per query port q:
  - A candidate is any entry with valid=1, we=1 and rt == q_addr[q].
  - The youngest candidate wins: lowest stage index first; within a stage, the highest lane.
  - q_hit = 1 if any candidate exists.
  - If the winner has m2r=0: q_ready=1, q_data = result.
  - If the winner has m2r=1 and stage > LOAD_STAGE: q_ready=1, q_data = mdata.
  - Otherwise (m2r=1 at stage <= LOAD_STAGE): q_ready=0, q_data=0. The issuer must stall.
  - An older ready match never overrides a younger not-ready match.
  - No candidate: q_hit=0, q_ready=0, q_data=0.
- Register address 0 is not special.
- Widths are fixed; there is no arithmetic beyond comparators and priority selection.

Optional Feature:
- Macro: SPU_RESULT_PIPE_WB_FWD_EN.
- Defined: the forwarding search also covers the wb output entry (stage DEPTH), at lowest priority. It returns wb_data with q_ready=1.
- Undefined: stage DEPTH is excluded from the search; the register file's write-before-read covers that case. All other behaviour is identical.

Test Plan:
- Basic latency: reset=0 for 2 cycles, then release. Issue lane0 {we=1, m2r=0, rt=5, result=0xA5...A5} at cycle 0 → wb_we[0]=1, wb_rt=5, wb_data=0xA5...A5 at cycle 6 only. All outputs are 0 during reset.
- Load path: issue lane1 {m2r=1, rt=9}; drive ld_data[1]=0x1234 in cycle 1 → q_addr=9 gives hit=1, ready=0 at stage 1, then hit=1, ready=1, data=0x1234 from stage 2. wb_data[1]=0x1234 at cycle 6.
- Priority: stage 3 holds rt=4 with 0x11; stage 2 holds rt=4 in lanes 0 and 1 with 0x22 and 0x33 → q_data=0x33. Replace the lane 1 entry with a not-ready load → ready=0 and data=0.
- Stall: assert stall for 3 cycles while the entry is in stage 4 → wb appears 3 cycles late, with exactly one wb_we pulse. in_valid during the stall is not captured.
- Flush: entries in stages 1, 2 and 3; pulse flush with FLUSH_DEPTH=2 → only the stage-3 entry reaches wb. q_hit for the flushed rt drops the next cycle. Repeat with stall=1 and flush=1 at the same time.
- Reset mid-flight: 6 entries in flight, reset=0 for one edge → no wb_we ever asserts for them, and all q_hit=0.
